rc_res_calc: RTL

- Downstream consumer of the RC time-to-digital timer.
- Accepts a raw 24-bit charge-time count plus the timer's overflow flag, and converts it to an 8-bit resistance code: R = count / DIVISOR, where DIVISOR = CLK_MHZ*CAP_PF*LN2_X100.
- Division is iterative (one quotient bit per clock), so there is no wide combinational divider in the top-level path.
- The result is clamped to 8 bits and presented with a one-cycle valid pulse to the output pins.

---
 rtl/rc_res_calc_pkg.sv | 16 +
 rtl/rc_res_calc_if.sv | 24 ++
 rtl/rc_res_calc_seq_udiv.sv | 67 ++++++
 rtl/rc_res_calc.sv | 100 ++++++++++
 4 files changed

// File: rtl/rc_res_calc_pkg.sv
// Shared constants and state encoding for the RC timer resistance calculator.
// The divisor folds clock rate, capacitance and ln2 into one integer constant.
package rc_tdc_pkg;
  localparam int CLK_MHZ    = 50;
  localparam int CAP_PF     = 100;
  localparam int LN2_X100   = 69;
  localparam int RC_DIVISOR = CLK_MHZ * CAP_PF * LN2_X100;
  localparam int COUNT_W    = 24;
  localparam int OUT_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } calc_state_t;
endpackage

// File: rtl/rc_res_calc_if.sv
// Count-in / result-out bundle between the timer side and the calculator.
interface rc_res_calc_if #(
  parameter int COUNT_W = rc_tdc_pkg::COUNT_W,
  parameter int OUT_W   = rc_tdc_pkg::OUT_W
) ();
  logic [COUNT_W-1:0] count_in;
  logic               count_valid;
  logic               overflow_in;
  logic               busy;
  logic [OUT_W-1:0]   res_out;
  logic               res_valid;
  logic               res_sat;
  logic               dropped;

  modport master (
    output count_in, count_valid, overflow_in,
    input  busy, res_out, res_valid, res_sat, dropped
  );

  modport slave (
    input  count_in, count_valid, overflow_in,
    output busy, res_out, res_valid, res_sat, dropped
  );
endinterface

// File: rtl/rc_res_calc_seq_udiv.sv
// Restoring unsigned divider by a constant, one quotient bit per clock, MSB first.
// done/quotient/remainder are the next-state values so the caller can capture on the final edge.
module seq_udiv #(
  parameter int DVD_W   = 24,
  parameter int DVS_W   = 20,
  parameter int DIVISOR = 345000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W:0]   remainder
);
  localparam int CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;
  localparam logic [DVS_W:0] DVS = (DVS_W+1)'(DIVISOR);

  // quo_q doubles as dividend shift register: dividend bits leave at the MSB,
  // quotient bits enter at the LSB.
  logic [DVD_W-1:0] quo_q, quo_d;
  logic [DVS_W:0]   rem_q, rem_d, rem_sh;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    rem_sh = {rem_q[DVS_W-1:0], quo_q[DVD_W-1]};
    if (start) begin
      quo_d = dividend;
      rem_d = '0;
      cnt_d = CNT_W'(DVD_W - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      if (rem_sh >= DVS) begin
        rem_d = rem_sh - DVS;
        quo_d = {quo_q[DVD_W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh;
        quo_d = {quo_q[DVD_W-2:0], 1'b0};
      end
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done      = run_q && (cnt_q == '0) && !start;
  assign quotient  = quo_d;
  assign remainder = rem_d;
endmodule

// File: rtl/rc_res_calc.sv
// Converts an RC timer charge count into a clamped resistance code (count / DIVISOR).
// Overflowed counts bypass the divider and report saturation immediately.
module rc_res_calc #(
  parameter int COUNT_W = rc_tdc_pkg::COUNT_W,
  parameter int DIV_W   = 20,
  parameter int DIVISOR = rc_tdc_pkg::RC_DIVISOR,
  parameter int OUT_W   = rc_tdc_pkg::OUT_W
) (
  input  logic         clk,
  input  logic         reset,
  rc_res_calc_if.slave bus
);
  import rc_tdc_pkg::*;

  if (DIVISOR == 0) begin : g_div_chk
    $fatal(1, "rc_res_calc: DIVISOR must be nonzero");
  end

  calc_state_t        state_q, state_d;
  logic [OUT_W-1:0]   res_out_q, res_out_d;
  logic               res_sat_q, res_sat_d;
  logic               res_valid_q, res_valid_d;
  logic               dropped_q, dropped_d;
  logic               div_start, div_done, clamp;
  logic [COUNT_W-1:0] div_quo;
  logic [DIV_W:0]     div_rem;

  seq_udiv #(
    .DVD_W   (COUNT_W),
    .DVS_W   (DIV_W),
    .DIVISOR (DIVISOR)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (bus.count_in),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign clamp = |div_quo[COUNT_W-1:OUT_W];

  always_comb begin
    state_d     = state_q;
    res_out_d   = res_out_q;
    res_sat_d   = res_sat_q;
    res_valid_d = 1'b0;
    dropped_d   = dropped_q | (bus.count_valid && (state_q != IDLE));
    div_start   = 1'b0;
    unique case (state_q)
      IDLE: if (bus.count_valid) begin
        if (bus.overflow_in) begin
          state_d     = DONE;
          res_out_d   = '1;
          res_sat_d   = 1'b1;
          res_valid_d = 1'b1;
        end else begin
          div_start = 1'b1;
          state_d   = DIV;
        end
      end
      DIV: if (div_done) begin
        state_d     = DONE;
        res_out_d   = clamp ? '1 : div_quo[OUT_W-1:0];
        res_sat_d   = clamp;
        res_valid_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      res_out_q   <= '0;
      res_sat_q   <= 1'b0;
      res_valid_q <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_out_q   <= res_out_d;
      res_sat_q   <= res_sat_d;
      res_valid_q <= res_valid_d;
      dropped_q   <= dropped_d;
    end
  end

  // A restoring divider must always leave a remainder below the divisor.
  always_ff @(posedge clk) begin
    if (!reset && div_done) assert (div_rem < (DIV_W+1)'(DIVISOR));
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.res_out   = res_out_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_sat   = res_sat_q;
  assign bus.dropped   = dropped_q;
endmodule
